// File: rtl/tetris_pkg.sv
// Shared Tetris definitions: draw modes, plotter state encoding and default
// playfield geometry used by both the plotter and the game control.
package tetris_pkg;

  localparam logic [1:0] MODE_FILL    = 2'b00;
  localparam logic [1:0] MODE_OUTLINE = 2'b01;
  localparam logic [1:0] MODE_CLEAR   = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLOT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEF_CELL_W    = 4;
  localparam int DEF_CELL_H    = 4;
  localparam int DEF_GRID_COLS = 10;
  localparam int DEF_GRID_ROWS = 20;
  localparam int DEF_ORIGIN_X  = 40;

  // Bits needed to index n items, never less than one.
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cell_plotter_raster_counter.sv
// Two-dimensional px/py scan counter: px runs fastest, both wrap at the cell
// edge, and last flags the final pixel of the cell.
module raster_counter
  import tetris_pkg::*;
#(
  parameter int CELL_W = DEF_CELL_W,
  parameter int CELL_H = DEF_CELL_H,
  localparam int PX_W  = width_of(CELL_W),
  localparam int PY_W  = width_of(CELL_H)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            clear,
  input  logic            step,
  output logic [PX_W-1:0] px,
  output logic [PY_W-1:0] py,
  output logic [PX_W-1:0] nxt_px,
  output logic [PY_W-1:0] nxt_py,
  output logic            last
);

  localparam logic [PX_W-1:0] PX_LAST = PX_W'(CELL_W - 1);
  localparam logic [PY_W-1:0] PY_LAST = PY_W'(CELL_H - 1);

  logic [PX_W-1:0] px_q;
  logic [PY_W-1:0] py_q;
  logic            px_end;
  logic            py_end;

  assign px_end = (px_q == PX_LAST);
  assign py_end = (py_q == PY_LAST);

  // The successor position is independent of step so the parent can
  // register the next pixel's address in the same cycle it advances.
  always_comb begin
    nxt_px = px_q + 1'b1;
    nxt_py = py_q;
    if (px_end) begin
      nxt_px = '0;
      nxt_py = py_end ? '0 : py_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      px_q <= '0;
      py_q <= '0;
    end else if (clear) begin
      px_q <= '0;
      py_q <= '0;
    end else if (step) begin
      px_q <= nxt_px;
      py_q <= nxt_py;
    end
  end

  assign px   = px_q;
  assign py   = py_q;
  assign last = px_end && py_end;

endmodule

// File: rtl/cell_plotter.sv
// Grid-cell rasteriser: turns one (col,row,colour,mode) request into a burst
// of single-pixel writes on the vga_adapter plot bus, with ready/done/err.
module cell_plotter
  import tetris_pkg::*;
#(
  parameter int X_W       = 8,
  parameter int Y_W       = 7,
  parameter int COLOUR_W  = 6,
  parameter int CELL_W    = DEF_CELL_W,
  parameter int CELL_H    = DEF_CELL_H,
  parameter int GRID_COLS = DEF_GRID_COLS,
  parameter int GRID_ROWS = DEF_GRID_ROWS,
  parameter int ORIGIN_X  = DEF_ORIGIN_X,
  parameter int ORIGIN_Y  = 0,
  parameter int BG_COLOUR = 0,
  localparam int COL_W    = width_of(GRID_COLS),
  localparam int ROW_W    = width_of(GRID_ROWS)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                req,
  input  logic [COL_W-1:0]    col,
  input  logic [ROW_W-1:0]    row,
  input  logic [COLOUR_W-1:0] colour_in,
  input  logic [1:0]          mode,
  output logic                ready,
  output logic [X_W-1:0]      X,
  output logic [Y_W-1:0]      Y,
  output logic [COLOUR_W-1:0] colour,
  output logic                writeEn,
  output logic                done,
  output logic                err
);

  localparam int PX_W = width_of(CELL_W);
  localparam int PY_W = width_of(CELL_H);
  localparam logic [PX_W-1:0]     PX_LAST = PX_W'(CELL_W - 1);
  localparam logic [PY_W-1:0]     PY_LAST = PY_W'(CELL_H - 1);
  localparam logic [COLOUR_W-1:0] BG      = COLOUR_W'(BG_COLOUR);

  if (ORIGIN_X + GRID_COLS * CELL_W > 2 ** X_W) begin : g_bad_x
    $fatal(1, "cell_plotter: playfield does not fit in X_W");
  end
  if (ORIGIN_Y + GRID_ROWS * CELL_H > 2 ** Y_W) begin : g_bad_y
    $fatal(1, "cell_plotter: playfield does not fit in Y_W");
  end
  if (BG_COLOUR >= 2 ** COLOUR_W) begin : g_bad_bg
    $fatal(1, "cell_plotter: BG_COLOUR does not fit in COLOUR_W");
  end

  function automatic logic [X_W-1:0] pix_x(input logic [COL_W-1:0] c,
                                           input logic [PX_W-1:0]  p);
    logic [31:0] s;
    s = 32'(ORIGIN_X) + 32'(c) * 32'(CELL_W) + 32'(p);
    return s[X_W-1:0];
  endfunction

  function automatic logic [Y_W-1:0] pix_y(input logic [ROW_W-1:0] r,
                                           input logic [PY_W-1:0]  q);
    logic [31:0] s;
    s = 32'(ORIGIN_Y) + 32'(r) * 32'(CELL_H) + 32'(q);
    return s[Y_W-1:0];
  endfunction

  // Mode 2'b11 falls through to fill.
  function automatic logic [COLOUR_W-1:0] pix_colour(input logic [1:0]          m,
                                                     input logic [COLOUR_W-1:0] c,
                                                     input logic [PX_W-1:0]     p,
                                                     input logic [PY_W-1:0]     q);
    logic                border;
    logic [COLOUR_W-1:0] res;
    border = (p == '0) || (p == PX_LAST) || (q == '0) || (q == PY_LAST);
    case (m)
      MODE_CLEAR:   res = BG;
      MODE_OUTLINE: res = border ? c : BG;
      default:      res = c;
    endcase
    return res;
  endfunction

  state_t                state_q, state_n;
  logic [COL_W-1:0]      col_q;
  logic [ROW_W-1:0]      row_q;
  logic [COLOUR_W-1:0]   colour_q;
  logic [1:0]            mode_q;
  logic                  latch, clear, step;
  logic [PX_W-1:0]       px, nxt_px;
  logic [PY_W-1:0]       py, nxt_py;
  logic                  last;
  logic                  ready_n, we_n, done_n, err_n;
  logic [X_W-1:0]        x_n;
  logic [Y_W-1:0]        y_n;
  logic [COLOUR_W-1:0]   colour_n;

  raster_counter #(
    .CELL_W (CELL_W),
    .CELL_H (CELL_H)
  ) u_raster (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (clear),
    .step    (step),
    .px      (px),
    .py      (py),
    .nxt_px  (nxt_px),
    .nxt_py  (nxt_py),
    .last    (last)
  );

  // Outputs are registered, so the pixel shown in a cycle is computed one
  // cycle ahead: at accept for (0,0), then from the counter's successor.
  always_comb begin
    state_n  = state_q;
    ready_n  = ready;
    x_n      = X;
    y_n      = Y;
    colour_n = colour;
    we_n     = 1'b0;
    done_n   = 1'b0;
    err_n    = 1'b0;
    latch    = 1'b0;
    clear    = 1'b0;
    step     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ready_n = 1'b1;
        if (req) begin
          latch = 1'b1;
          if (32'(col) >= 32'(GRID_COLS) || 32'(row) >= 32'(GRID_ROWS)) begin
            err_n = 1'b1;
          end else begin
            clear    = 1'b1;
            state_n  = ST_PLOT;
            ready_n  = 1'b0;
            we_n     = 1'b1;
            x_n      = pix_x(col, '0);
            y_n      = pix_y(row, '0);
            colour_n = pix_colour(mode, colour_in, '0, '0);
          end
        end
      end
      ST_PLOT: begin
        if (last) begin
          state_n = ST_DONE;
          done_n  = 1'b1;
        end else begin
          step     = 1'b1;
          we_n     = 1'b1;
          x_n      = pix_x(col_q, nxt_px);
          y_n      = pix_y(row_q, nxt_py);
          colour_n = pix_colour(mode_q, colour_q, nxt_px, nxt_py);
        end
      end
      ST_DONE: begin
        state_n = ST_IDLE;
        ready_n = 1'b1;
      end
      default: begin
        state_n = ST_IDLE;
        ready_n = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      ready   <= 1'b1;
      X       <= '0;
      Y       <= '0;
      colour  <= '0;
      writeEn <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state_q <= state_n;
      ready   <= ready_n;
      X       <= x_n;
      Y       <= y_n;
      colour  <= colour_n;
      writeEn <= we_n;
      done    <= done_n;
      err     <= err_n;
    end
  end

  always_ff @(posedge clk) begin
    if (latch) begin
      col_q    <= col;
      row_q    <= row;
      colour_q <= colour_in;
      mode_q   <= mode;
    end
  end

  logic unused_pos;
  assign unused_pos = ^{px, py};

endmodule

// File: tb/tb_cell_plotter.sv
// Bench for cell_plotter: default build plus a 1x2-cell, 5-column build,
// each tracked by a transaction-level expected-output model.
module tb_cell_plotter;

  typedef struct packed {
    bit ready;
    bit we;
    bit done;
    bit err;
    int x;
    int y;
    int c;
  } exp_t;

  localparam exp_t IDLE_E = '{ready: 1'b1, we: 1'b0, done: 1'b0, err: 1'b0, x: 0, y: 0, c: 0};

  int checks   = 0;
  int failures = 0;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;

  logic       req0 = 1'b0;
  logic [3:0] col0 = '0;
  logic [4:0] row0 = '0;
  logic [5:0] cin0 = '0;
  logic [1:0] mode0 = '0;
  logic       ready0, we0, done0, err0;
  logic [7:0] x0;
  logic [6:0] y0;
  logic [5:0] colour0;

  logic       req1 = 1'b0;
  logic [2:0] col1 = '0;
  logic [4:0] row1 = '0;
  logic [5:0] cin1 = '0;
  logic [1:0] mode1 = '0;
  logic       ready1, we1, done1, err1;
  logic [7:0] x1;
  logic [6:0] y1;
  logic [5:0] colour1;

  always #5 clk = ~clk;

  cell_plotter dut0 (
    .clk (clk), .reset_n (reset_n), .req (req0), .col (col0), .row (row0),
    .colour_in (cin0), .mode (mode0), .ready (ready0), .X (x0), .Y (y0),
    .colour (colour0), .writeEn (we0), .done (done0), .err (err0)
  );

  cell_plotter #(.CELL_W(1), .CELL_H(2), .GRID_COLS(5)) dut1 (
    .clk (clk), .reset_n (reset_n), .req (req1), .col (col1), .row (row1),
    .colour_in (cin1), .mode (mode1), .ready (ready1), .X (x1), .Y (y1),
    .colour (colour1), .writeEn (we1), .done (done1), .err (err1)
  );

  // Model: geometry per unit, and a queue of expected per-cycle outputs.
  function automatic int cw(input int k);    return (k == 0) ? 4 : 1; endfunction
  function automatic int ch(input int k);    return (k == 0) ? 4 : 2; endfunction
  function automatic int gcols(input int k); return (k == 0) ? 10 : 5; endfunction

  function automatic int pixcol(input int md, input int ci, input int px, input int py, input int k);
    bit border;
    border = (px == 0) || (px == cw(k) - 1) || (py == 0) || (py == ch(k) - 1);
    if (md == 2) return 0;
    if (md == 1) return border ? ci : 0;
    return ci;
  endfunction

  exp_t qb [2][64];
  int   qh [2] = '{0, 0};
  int   qn [2] = '{0, 0};
  exp_t cur [2];

  task automatic push(input int k, input exp_t e);
    qb[k][(qh[k] + qn[k]) % 64] = e;
    qn[k]++;
  endtask

  task automatic model_edge(input int k, input bit rq, input int c, input int r, input int ci, input int md);
    exp_t e;
    if (cur[k].ready && rq) begin
      if (c >= gcols(k) || r >= 20) begin
        e = IDLE_E;
        e.err = 1'b1;
        push(k, e);
      end else begin
        for (int py = 0; py < ch(k); py++) begin
          for (int px = 0; px < cw(k); px++) begin
            e = IDLE_E;
            e.ready = 1'b0;
            e.we = 1'b1;
            e.x = (40 + c * cw(k) + px) % 256;
            e.y = (r * ch(k) + py) % 128;
            e.c = pixcol(md, ci, px, py, k);
            push(k, e);
          end
        end
        e = IDLE_E;
        e.ready = 1'b0;
        e.done = 1'b1;
        push(k, e);
      end
    end
    if (qn[k] > 0) begin
      cur[k] = qb[k][qh[k]];
      qh[k] = (qh[k] + 1) % 64;
      qn[k]--;
    end else begin
      cur[k] = IDLE_E;
    end
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      qn[0] = 0;
      qn[1] = 0;
      cur[0] = IDLE_E;
      cur[1] = IDLE_E;
    end else begin
      model_edge(0, req0, int'(col0), int'(row0), int'(cin0), int'(mode0));
      model_edge(1, req1, int'(col1), int'(row1), int'(cin1), int'(mode1));
    end
  end

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp(input int k, input logic rdy, input logic we, input logic dn, input logic er,
                     input int x, input int y, input int c);
    check($sformatf("u%0d_ready", k), int'(rdy), int'(cur[k].ready));
    check($sformatf("u%0d_writeEn", k), int'(we), int'(cur[k].we));
    check($sformatf("u%0d_done", k), int'(dn), int'(cur[k].done));
    check($sformatf("u%0d_err", k), int'(er), int'(cur[k].err));
    if (cur[k].we) begin
      check($sformatf("u%0d_X", k), x, cur[k].x);
      check($sformatf("u%0d_Y", k), y, cur[k].y);
      check($sformatf("u%0d_colour", k), c, cur[k].c);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      cmp(0, ready0, we0, done0, err0, int'(x0), int'(y0), int'(colour0));
      cmp(1, ready1, we1, done1, err1, int'(x1), int'(y1), int'(colour1));
    end
  end

  int wx [64];
  int wy [64];
  int wc [64];

  // Issues one request on unit 0 and records what it produces; inputs are
  // scrambled after acceptance to show only the latched copy is used.
  task automatic run0(input int c, input int r, input int ci, input int md, input int cycles,
                      output int nw, output int dc, output int rc, output int ne, output int lo);
    req0 = 1'b1; col0 = 4'(c); row0 = 5'(r); cin0 = 6'(ci); mode0 = 2'(md);
    nw = 0; dc = -1; rc = -1; ne = 0; lo = 0;
    for (int i = 1; i <= cycles; i++) begin
      @(negedge clk);
      req0 = 1'b0;
      col0 = 4'($urandom); row0 = 5'($urandom); cin0 = 6'($urandom); mode0 = 2'($urandom);
      if (we0) begin
        wx[nw] = int'(x0); wy[nw] = int'(y0); wc[nw] = int'(colour0);
        nw++;
      end
      if (done0 && dc < 0) dc = i;
      if (ready0 && rc < 0) rc = i;
      if (!ready0) lo++;
      if (err0) ne++;
    end
  endtask

  function automatic int count_colour(input int n, input int v);
    int cnt = 0;
    for (int i = 0; i < n; i++) if (wc[i] == v) cnt++;
    return cnt;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int nw, dc, rc, ne, lo;
    int acc, nd, nw1;
    int dcyc [8];
    cur[0] = IDLE_E;
    cur[1] = IDLE_E;

    repeat (2) @(negedge clk);
    check("rst_ready", int'(ready0), 1);
    check("rst_writeEn", int'(we0), 0);
    check("rst_X", int'(x0), 0);
    check("rst_Y", int'(y0), 0);
    check("rst_colour", int'(colour0), 0);
    check("rst_done_err", int'({done0, err0}), 0);
    check("rst_ready_u1", int'(ready1), 1);
    reset_n = 1'b1;
    @(negedge clk);

    run0(0, 0, 'h3F, 0, 24, nw, dc, rc, ne, lo);
    check("t1_writes", nw, 16);
    check("t1_x_first", wx[0], 40);
    check("t1_x_second", wx[1], 41);
    check("t1_y_first", wy[0], 0);
    check("t1_y_fifth", wy[4], 1);
    check("t1_x_last", wx[15], 43);
    check("t1_y_last", wy[15], 3);
    check("t1_colour", count_colour(16, 'h3F), 16);
    check("t1_done_cycle", dc, 17);
    check("t1_ready_cycle", rc, 18);

    run0(9, 19, 'h30, 1, 24, nw, dc, rc, ne, lo);
    check("t2_writes", nw, 16);
    check("t2_x_first", wx[0], 76);
    check("t2_y_first", wy[0], 76);
    check("t2_x_last", wx[15], 79);
    check("t2_y_last", wy[15], 79);
    check("t2_border_count", count_colour(16, 'h30), 12);
    check("t2_interior_a", wc[5], 0);
    check("t2_interior_b", wc[10], 0);
    check("t2_edge", wc[4], 'h30);

    run0(10, 5, 'h11, 0, 6, nw, dc, rc, ne, lo);
    check("t3_col_writes", nw, 0);
    check("t3_col_err", ne, 1);
    check("t3_col_ready_low", lo, 0);
    run0(3, 20, 'h11, 0, 6, nw, dc, rc, ne, lo);
    check("t3_row_writes", nw, 0);
    check("t3_row_err", ne, 1);
    check("t3_row_ready_low", lo, 0);

    run0(3, 2, 'h2A, 2, 24, nw, dc, rc, ne, lo);
    check("t4_clear_writes", nw, 16);
    check("t4_clear_x_first", wx[0], 52);
    check("t4_clear_y_first", wy[0], 8);
    check("t4_clear_x_last", wx[15], 55);
    check("t4_clear_y_last", wy[15], 11);
    check("t4_clear_bg", count_colour(16, 0), 16);
    run0(3, 2, 'h15, 3, 24, nw, dc, rc, ne, lo);
    check("t4_m3_writes", nw, 16);
    check("t4_m3_fill", count_colour(16, 'h15), 16);
    check("t4_m3_done_cycle", dc, 17);

    // Abort a raster with reset while its 7th pixel is on the bus.
    req0 = 1'b1; col0 = 4'd1; row0 = 5'd1; cin0 = 6'h07; mode0 = 2'd0;
    nw = 0;
    for (int i = 1; i <= 20 && nw < 7; i++) begin
      @(negedge clk);
      req0 = 1'b0;
      if (we0) nw++;
    end
    check("t5_reached_7th", nw, 7);
    reset_n = 1'b0;
    #1;
    check("t5_writeEn_now", int'(we0), 0);
    check("t5_ready_now", int'(ready0), 1);
    check("t5_done_now", int'(done0), 0);
    nd = 0;
    repeat (2) begin
      @(negedge clk);
      if (done0 || we0) nd++;
    end
    reset_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (done0 || we0) nd++;
    end
    check("t5_no_activity", nd, 0);
    run0(2, 7, 'h0C, 0, 24, nw, dc, rc, ne, lo);
    check("t5_after_writes", nw, 16);
    check("t5_after_done", dc, 17);

    // Unit 1: req held high through three back-to-back requests.
    req1 = 1'b1; col1 = 3'd4; row1 = 5'd19; cin1 = 6'h21; mode1 = 2'd1;
    acc = 1; nd = 0; nw1 = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (we1) nw1++;
      if (done1 && nd < 8) begin dcyc[nd] = i; nd++; end
      if (ready1 && req1) begin
        if (acc == 3) req1 = 1'b0;
        else acc++;
      end
      col1 = 3'($urandom_range(0, 4)); row1 = 5'($urandom_range(0, 19));
      cin1 = 6'($urandom); mode1 = 2'($urandom);
    end
    check("t6_writes", nw1, 6);
    check("t6_dones", nd, 3);
    check("t6_done_1", dcyc[0], 3);
    check("t6_done_2", dcyc[1], 7);
    check("t6_done_3", dcyc[2], 11);

    req1 = 1'b1; col1 = 3'd0; row1 = 5'd0; cin1 = 6'h3C; mode1 = 2'd0;
    nw1 = 0; nd = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (we1) nw1++;
      if (done1) nd++;
      req1 = (i == 2);
    end
    check("t6_pulse_writes", nw1, 2);
    check("t6_pulse_dones", nd, 1);

    // Randomised traffic on both units, including out-of-range requests.
    for (int i = 0; i < 600; i++) begin
      req0 = ($urandom_range(0, 3) == 0);
      col0 = 4'($urandom_range(0, 11)); row0 = 5'($urandom_range(0, 21));
      cin0 = 6'($urandom); mode0 = 2'($urandom);
      req1 = ($urandom_range(0, 2) == 0);
      col1 = 3'($urandom_range(0, 6)); row1 = 5'($urandom_range(0, 21));
      cin1 = 6'($urandom); mode1 = 2'($urandom);
      @(negedge clk);
    end
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (30) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cell_plotter.md
Name: cell_plotter

Overview:
- Parametrised grid-cell rasteriser for the Tetris playfield.
- Accepts one request naming a playfield cell (col, row), a colour and a draw mode.
- Emits one pixel write per cycle on the X/Y/colour/writeEn plot bus feeding vga_adapter.
- Replaces per-pixel drawing loops in control; generalises cell size, grid size, origin and colour width, and adds fill/outline/clear modes, range checking and a ready/done handshake.

Parameters:
- X_W, 8, width of X output (160-wide frame)
- Y_W, 7, width of Y output (120-tall frame)
- COLOUR_W, 6, colour width (2 bits per channel)
- CELL_W, 4, cell width in pixels, >=1
- CELL_H, 4, cell height in pixels, >=1
- GRID_COLS, 10, playfield columns
- GRID_ROWS, 20, playfield rows
- ORIGIN_X, 40, pixel X of cell (0,0) top-left
- ORIGIN_Y, 0, pixel Y of cell (0,0) top-left
- BG_COLOUR, 0, colour used by clear mode and outline interior
- Derived, not overridable: COL_W = max(1, clog2(GRID_COLS)); ROW_W = max(1, clog2(GRID_ROWS)).

Ports:
- clk  in  1  system clock (CLOCK_50)
- reset_n  in  1  asynchronous active-low reset
- req  in  1  request strobe, sampled only while ready=1
- col  in  COL_W  target column
- row  in  ROW_W  target row
- colour_in  in  COLOUR_W  draw colour
- mode  in  2  00 fill, 01 outline, 10 clear, 11 treated as fill
- ready  out  1  idle, can accept req
- X  out  X_W  pixel x
- Y  out  Y_W  pixel y
- colour  out  COLOUR_W  pixel colour
- writeEn  out  1  pixel write strobe
- done  out  1  one-cycle pulse after the last pixel
- err  out  1  one-cycle pulse: out-of-range request rejected

Behaviour:
- Reset (async, immediate): state IDLE; ready=1; X=0, Y=0, colour=0, writeEn=0, done=0, err=0; counters cleared. Reset mid-raster aborts it; no further writes occur.
- All outputs are registered.
- States: IDLE, PLOT, DONE.
- IDLE, ready=1. On req=1, latch col, row, colour_in and mode.
  - If col>=GRID_COLS or row>=GRID_ROWS: next cycle err=1, stay IDLE, ready stays 1, no writes.
  - Otherwise: next state PLOT, ready=0; px=0, py=0.
- PLOT, one pixel per cycle:
  - writeEn=1.
  - X = ORIGIN_X + col*CELL_W + px, truncated to X_W.
  - Y = ORIGIN_Y + row*CELL_H + py, truncated to Y_W.
  - Scan order: px increments; at px=CELL_W-1 it wraps to 0 and py increments.
  - After pixel (CELL_W-1, CELL_H-1), next state is DONE.
- Colour per pixel:
  - fill: latched colour.
  - clear: BG_COLOUR.
  - outline: latched colour if px==0, px==CELL_W-1, py==0 or py==CELL_H-1; else BG_COLOUR. CELL_W or CELL_H =1 makes every pixel border.
- DONE: writeEn=0, done=1, ready=0 for one cycle, then IDLE with ready=1.
- Timing: req accepted at edge 0; writes are visible in cycles 1..N where N=CELL_W*CELL_H; done in cycle N+1; ready in cycle N+2.
- req while ready=0 is ignored, not queued.
- Inputs change during PLOT: no effect, latched copy used.
- Back-to-back: req held high is accepted again in the first cycle ready=1.
- Elaboration checks (fatal assert):
  - ORIGIN_X + GRID_COLS*CELL_W <= 2**X_W.
  - ORIGIN_Y + GRID_ROWS*CELL_H <= 2**Y_W.
  - BG_COLOUR < 2**COLOUR_W.

Decomposition:
- Shared package tetris_pkg:
  - mode constants MODE_FILL=2'b00, MODE_OUTLINE=2'b01, MODE_CLEAR=2'b10;
  - state encoding constants;
  - default geometry constants (CELL_W, CELL_H, GRID_COLS, GRID_ROWS, ORIGIN_X), shared with control.
- One natural sub-module: raster_counter, a parametrised px/py 2-D counter with wrap and a last flag. The FSM and address/colour generation stay in cell_plotter.

Test Plan:
1. Defaults; reset; req with col=0, row=0, colour_in=6'h3F, mode=fill.
   - Required: 16 writes in cycles 1..16, X 40..43, Y 0..3, colour 3F; done in cycle 17; ready in cycle 18.
2. col=9, row=19, colour 6'h30, mode=outline.
   - Required: X 76..79, Y 76..79.
   - 12 border pixels colour 30; 4 interior pixels (77..78, 77..78) colour 0.
3. col=10, row=5, req=1.
   - Required: err=1 next cycle, writeEn never asserts, ready stays 1.
   - Repeat with row=20: same response.
4. Mode=clear at col=3, row=2; then mode=2'b11.
   - Required: clear writes BG_COLOUR to X 52..55, Y 8..11.
   - 2'b11 behaves exactly as fill.
5. Assert reset_n=0 at the 7th write.
   - Required: writeEn=0 and ready=1 immediately; no done pulse.
   - A request after release is serviced fully.
6. CELL_W=1, CELL_H=2, GRID_COLS=5 build; req held high for 3 requests.
   - Required: 2 writes per request; each request starts the cycle ready rises.
   - req pulsed during PLOT is ignored.
